// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a stalling CPU MEM stage.
// An accepted access stalls the pipeline for LATENCY+1 cycles, then pulses rdy for one cycle.
module dmem_responder #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned AW      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [15:0] addr,
  input  logic [15:0] sdata,
  output logic [15:0] ldata,
  output logic        stall_mem,
  output logic        rdy
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   sdata_q;
  logic          write_q;
  logic          rdy_q;
  logic [15:0]   ldata_q;

  logic [15:0]   mem [2**AW];

  logic req;
  logic commit_wr;

  assign req = re_mem | we_mem;

  // A reset that lands in DONE must still suppress the pending write.
  assign commit_wr = ~rst_n && (state_q == StDone) && write_q;

  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[addr_q] <= sdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      ldata_q <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          rdy_q <= 1'b0;
          if (req) begin
            addr_q  <= addr[AW-1:0];
            sdata_q <= sdata;
            write_q <= we_mem;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            rdy_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          // The pipeline advances this cycle, so no request is accepted here.
          rdy_q <= 1'b0;
          if (!write_q) begin
            ldata_q <= mem[addr_q];
          end
          state_q <= StIdle;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    stall_mem = 1'b0;
    if (!rst_n) begin
      stall_mem = (state_q == StBusy) || ((state_q == StIdle) && req);
    end
  end

  assign rdy   = rdy_q;
  assign ldata = ldata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset/back-to-back sequences
// and a randomized phase checked against an associative-array memory model.
module tb_dmem_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        re_mem;
  logic        we_mem;
  logic [15:0] addr;
  logic [15:0] sdata;
  logic [15:0] ldata;
  logic        stall_mem;
  logic        rdy;

  int checks;
  int failures;

  logic [15:0] model [int];
  logic [15:0] exp_ld;

  typedef struct {
    logic        re;
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    bit          keep;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [9];

  dmem_responder #(
    .LATENCY(LAT),
    .AW     (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .re_mem   (re_mem),
    .we_mem   (we_mem),
    .addr     (addr),
    .sdata    (sdata),
    .ldata    (ldata),
    .stall_mem(stall_mem),
    .rdy      (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic churn();
    re_mem = 1'($urandom_range(0, 1));
    we_mem = 1'($urandom_range(0, 1));
    addr   = 16'($urandom);
    sdata  = 16'($urandom);
  endtask

  // Called at a negedge: that cycle is cycle 0. Returns at the negedge of cycle LAT+2.
  task automatic access(input logic re, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input bit keep, input logic [15:0] exp_l,
                        input string tag);
    re_mem = re;
    we_mem = we;
    addr   = a;
    sdata  = d;
    #1;
    chk({tag, ".stall_c0"}, {15'b0, stall_mem}, 16'd1);
    chk({tag, ".rdy_c0"}, {15'b0, rdy}, 16'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      churn();
      #1;
      chk({tag, ".stall_busy"}, {15'b0, stall_mem}, 16'd1);
      chk({tag, ".rdy_busy"}, {15'b0, rdy}, 16'd0);
    end
    @(negedge clk);
    churn();
    if (keep) re_mem = 1'b1;
    #1;
    chk({tag, ".stall_done"}, {15'b0, stall_mem}, 16'd0);
    chk({tag, ".rdy_done"}, {15'b0, rdy}, 16'd1);
    @(negedge clk);
    if (!keep) begin
      re_mem = 1'b0;
      we_mem = 1'b0;
      #1;
      chk({tag, ".stall_after"}, {15'b0, stall_mem}, 16'd0);
    end
    chk({tag, ".rdy_after"}, {15'b0, rdy}, 16'd0);
    chk({tag, ".ldata"}, ldata, exp_l);
  endtask

  // Model-driven access: expectation comes from the array model, not the DUT.
  task automatic op(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d,
                    input bit keep, input string tag);
    int key;
    key = int'(a & 16'h03FF);
    if (we) begin
      model[key] = d;
    end else if (re) begin
      exp_ld = model[key];
    end
    access(re, we, a, d, keep, exp_ld, tag);
  endtask

  initial begin
    logic [9:0] base [8];
    checks   = 0;
    failures = 0;
    exp_ld   = 16'h0000;

    tbl[0] = '{re: 1'b0, we: 1'b1, a: 16'h0005, d: 16'hBEEF, keep: 1'b0, exp: 16'h0000};
    tbl[1] = '{re: 1'b1, we: 1'b0, a: 16'h0005, d: 16'h0000, keep: 1'b0, exp: 16'hBEEF};
    tbl[2] = '{re: 1'b1, we: 1'b1, a: 16'h0010, d: 16'h1234, keep: 1'b0, exp: 16'hBEEF};
    tbl[3] = '{re: 1'b1, we: 1'b0, a: 16'h0010, d: 16'hFFFF, keep: 1'b0, exp: 16'h1234};
    tbl[4] = '{re: 1'b0, we: 1'b1, a: 16'h0403, d: 16'hAAAA, keep: 1'b0, exp: 16'h1234};
    tbl[5] = '{re: 1'b1, we: 1'b0, a: 16'h0003, d: 16'h0000, keep: 1'b0, exp: 16'hAAAA};
    tbl[6] = '{re: 1'b0, we: 1'b1, a: 16'h0020, d: 16'h0F0F, keep: 1'b1, exp: 16'hAAAA};
    tbl[7] = '{re: 1'b1, we: 1'b0, a: 16'hFC20, d: 16'h0000, keep: 1'b0, exp: 16'h0F0F};
    tbl[8] = '{re: 1'b1, we: 1'b0, a: 16'h0005, d: 16'h0000, keep: 1'b0, exp: 16'hBEEF};

    // Reset with a request present: stall must stay masked.
    rst_n  = 1'b1;
    re_mem = 1'b1;
    we_mem = 1'b1;
    addr   = 16'h0001;
    sdata  = 16'h9999;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.stall", {15'b0, stall_mem}, 16'd0);
    chk("rst.rdy", {15'b0, rdy}, 16'd0);
    chk("rst.ldata", ldata, 16'h0000);
    @(negedge clk);
    rst_n  = 1'b0;
    re_mem = 1'b0;
    we_mem = 1'b0;
    #1;
    chk("idle.stall", {15'b0, stall_mem}, 16'd0);
    repeat (3) @(negedge clk);
    chk("idle.rdy", {15'b0, rdy}, 16'd0);
    chk("idle.ldata", ldata, 16'h0000);

    for (int i = 0; i < 9; i++) begin
      access(tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].keep, tbl[i].exp,
             $sformatf("vec%0d", i));
      if (tbl[i].we) model[int'(tbl[i].a & 16'h03FF)] = tbl[i].d;
      else exp_ld = tbl[i].exp;
    end

    // ldata holds across idle cycles.
    repeat (4) @(negedge clk);
    #1;
    chk("hold.ldata", ldata, exp_ld);
    chk("hold.stall", {15'b0, stall_mem}, 16'd0);

    // Reset in BUSY cycle 2 aborts a pending write.
    op(1'b0, 1'b1, 16'h0007, 16'h0001, 1'b0, "rst_pre");
    re_mem = 1'b0;
    we_mem = 1'b1;
    addr   = 16'h0007;
    sdata  = 16'h5555;
    #1;
    chk("rstw.stall_c0", {15'b0, stall_mem}, 16'd1);
    @(negedge clk);
    churn();
    @(negedge clk);
    rst_n  = 1'b1;
    re_mem = 1'b0;
    we_mem = 1'b0;
    @(negedge clk);
    #1;
    chk("rstw.stall", {15'b0, stall_mem}, 16'd0);
    chk("rstw.rdy", {15'b0, rdy}, 16'd0);
    chk("rstw.ldata", ldata, 16'h0000);
    rst_n = 1'b0;
    exp_ld = 16'h0000;
    #1;
    chk("rstw.stall_idle", {15'b0, stall_mem}, 16'd0);
    repeat (LAT + 2) @(negedge clk);
    chk("rstw.rdy_idle", {15'b0, rdy}, 16'd0);
    op(1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, "rstw_read");

    // Randomized phase over a small aliased address pool.
    for (int j = 0; j < 8; j++) begin
      base[j] = 10'(j * 97 + 11);
      op(1'b0, 1'b1, {6'($urandom), base[j]}, 16'($urandom), 1'b0, "rnd_init");
    end
    for (int n = 0; n < 40; n++) begin
      int   sel;
      logic r;
      logic w;
      sel = $urandom_range(0, 2);
      r   = (sel != 1);
      w   = (sel != 0);
      op(r, w, {6'($urandom), base[$urandom_range(0, 7)]}, 16'($urandom),
         ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
    end
    re_mem = 1'b0;
    we_mem = 1'b0;
    @(negedge clk);
    #1;
    chk("end.stall", {15'b0, stall_mem}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
